local_endpoint: RTL



---
 rtl/local_endpoint_pkg.sv | 15 +
 rtl/endpoint_rx_buffer.sv | 42 ++++
 rtl/local_endpoint.sv | 123 ++++++++++++
 3 files changed

// File: rtl/local_endpoint_pkg.sv
// local_endpoint_pkg: shared link constants and FSM state types for the Local-port endpoint
`ifndef SIZE
`define SIZE 8
`endif
`ifndef BITS_DIR
`define BITS_DIR 3
`endif
`ifndef LOCAL_PORT
`define LOCAL_PORT 4
`endif
package local_endpoint_pkg;
    localparam int LOCAL_PORT = `LOCAL_PORT;
    typedef enum logic [1:0] {T_IDLE, T_REQ, T_REL} tx_state_e;
    typedef enum logic {R_IDLE, R_ACK} rx_state_e;
endpackage

// File: rtl/endpoint_rx_buffer.sv
// endpoint_rx_buffer: first-word fall-through FIFO holding words delivered by the router
module endpoint_rx_buffer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [AW:0]      cnt_q;
    logic             do_push, do_pop;
    assign full      = cnt_q == FULL_CNT;
    assign empty     = cnt_q == '0;
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign head_data = mem_q[rd_q];
    // Storage, pointers and occupancy; full is judged on the count before this cycle's pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= push_data;
                wr_q        <= wr_q + AW'(1);
            end
            if (do_pop) rd_q <= rd_q + AW'(1);
            cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/local_endpoint.sv
// local_endpoint: host-side endpoint on the router Local port with 4-phase TX/RX links and word counters
module local_endpoint
    import local_endpoint_pkg::*;
#(
    parameter int id        = -1,
    parameter int CNT_W     = 16,
    parameter int RXB_DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             host_tx_valid,
    output logic             host_tx_ready,
    input  logic [`SIZE-1:0] host_tx_data,
    output logic             net_tx_req,
    input  logic             net_tx_ack,
    output logic [`SIZE-1:0] net_tx_data,
    input  logic             net_rx_req,
    output logic             net_rx_ack,
    input  logic [`SIZE-1:0] net_rx_data,
    output logic             host_rx_valid,
    input  logic             host_rx_ready,
    output logic [`SIZE-1:0] host_rx_data,
    output logic [CNT_W-1:0] tx_count,
    output logic [CNT_W-1:0] rx_count
);
    if (id < -1 || RXB_DEPTH < 2 || (RXB_DEPTH & (RXB_DEPTH - 1)) != 0) begin : g_bad_param
        $error("local_endpoint: invalid id or RXB_DEPTH");
    end
    tx_state_e        tx_state_q, tx_state_d;
    rx_state_e        rx_state_q, rx_state_d;
    logic             ready_q, ready_d, req_q, req_d, ack_q, ack_d;
    logic [`SIZE-1:0] data_q, data_d;
    logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
    logic             push, full, empty;
    assign host_tx_ready = ready_q;
    assign net_tx_req    = req_q;
    assign net_tx_data   = data_q;
    assign net_rx_ack    = ack_q;
    assign host_rx_valid = !empty;
    assign tx_count      = tx_cnt_q;
    assign rx_count      = rx_cnt_q;
    endpoint_rx_buffer #(.WIDTH(`SIZE), .DEPTH(RXB_DEPTH)) u_rxb (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (net_rx_data),
        .pop       (host_rx_valid && host_rx_ready),
        .head_data (host_rx_data),
        .full      (full),
        .empty     (empty)
    );
    // TX sender: capture a host word, hold req until ack, count once ack has been released.
    always_comb begin
        tx_state_d = tx_state_q;
        ready_d    = ready_q;
        req_d      = req_q;
        data_d     = data_q;
        tx_cnt_d   = tx_cnt_q;
        case (tx_state_q)
            T_IDLE: begin
                ready_d = 1'b1;
                if (host_tx_valid && ready_q) begin
                    data_d     = host_tx_data;
                    req_d      = 1'b1;
                    ready_d    = 1'b0;
                    tx_state_d = T_REQ;
                end
            end
            T_REQ: if (net_tx_ack) begin
                req_d      = 1'b0;
                tx_state_d = T_REL;
            end
            T_REL: if (!net_tx_ack) begin
                tx_cnt_d   = tx_cnt_q + CNT_W'(1);
                ready_d    = 1'b1;
                tx_state_d = T_IDLE;
            end
            default: tx_state_d = T_IDLE;
        endcase
    end
    // RX receiver: accept a word only with buffer space, then hold ack until req drops.
    always_comb begin
        rx_state_d = rx_state_q;
        ack_d      = ack_q;
        rx_cnt_d   = rx_cnt_q;
        push       = 1'b0;
        case (rx_state_q)
            R_IDLE: if (net_rx_req && !full) begin
                push       = 1'b1;
                ack_d      = 1'b1;
                rx_cnt_d   = rx_cnt_q + CNT_W'(1);
                rx_state_d = R_ACK;
            end
            R_ACK: if (!net_rx_req) begin
                ack_d      = 1'b0;
                rx_state_d = R_IDLE;
            end
            default: rx_state_d = R_IDLE;
        endcase
    end
    // State and output registers; reset abandons any in-flight handshake uncounted.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state_q <= T_IDLE;
            rx_state_q <= R_IDLE;
            ready_q    <= 1'b0;
            req_q      <= 1'b0;
            ack_q      <= 1'b0;
            data_q     <= '0;
            tx_cnt_q   <= '0;
            rx_cnt_q   <= '0;
        end else begin
            tx_state_q <= tx_state_d;
            rx_state_q <= rx_state_d;
            ready_q    <= ready_d;
            req_q      <= req_d;
            ack_q      <= ack_d;
            data_q     <= data_d;
            tx_cnt_q   <= tx_cnt_d;
            rx_cnt_q   <= rx_cnt_d;
        end
    end
endmodule
